// File: rtl/ex_stage_8085_pipeline.sv
// rtl/ex_stage_8085_pipeline.sv - 8085 execute stage: ALU, S/Z/AC/P/CY flag register, EX/MEM pipeline register
// Optional EX-to-EX operand forwarding is enabled by defining EX_FWD_EN.
module ex_stage_8085_pipeline #(
   parameter int DW = 8,
   parameter int RW = 3
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          valid_in,
   input  logic [2:0]    op,
   input  logic [DW-1:0] a_in,
   input  logic [DW-1:0] b_in,
   input  logic [RW-1:0] src_a_in,
   input  logic [RW-1:0] src_b_in,
   input  logic          use_cy_in,
   input  logic [RW-1:0] rd_in,
   input  logic          wr_en_in,
   input  logic          flag_we_in,
   input  logic          stall,
   input  logic          flush,
   output logic          valid_out,
   output logic [DW-1:0] result_out,
   output logic [RW-1:0] rd_out,
   output logic          wr_en_out,
   output logic [4:0]    flags_out,
   output logic          err_out
);

   logic          r_valid;
   logic [DW-1:0] r_result;
   logic [RW-1:0] r_rd;
   logic          r_wr_en;
   logic [4:0]    r_flags;
   logic          r_err;

   logic [DW-1:0] w_a;
   logic [DW-1:0] w_b;
   logic          w_cin;
   logic [DW:0]   w_wide;
   logic [4:0]    w_nib;
   logic [DW-1:0] w_res;
   logic          w_cy;
   logic          w_ac;
   logic          w_op_ok;
   logic [4:0]    w_new_flags;

`ifdef EX_FWD_EN
   logic w_fwd_ok;
   assign w_fwd_ok = r_valid && r_wr_en;
   assign w_a = (w_fwd_ok && (r_rd == src_a_in)) ? r_result : a_in;
   assign w_b = (w_fwd_ok && (r_rd == src_b_in)) ? r_result : b_in;
`else
   logic w_unused_src;
   assign w_unused_src = ^{src_a_in, src_b_in};
   assign w_a = a_in;
   assign w_b = b_in;
`endif

   // CY register feeds the carry-in of ADC/SBB directly; flags update at the same edge
   assign w_cin = use_cy_in & r_flags[0];

   always_comb begin
      w_wide  = '0;
      w_nib   = '0;
      w_res   = '0;
      w_cy    = 1'b0;
      w_ac    = 1'b0;
      w_op_ok = 1'b1;
      case (op)
         3'b000: begin
            w_wide = {1'b0, w_a} + {1'b0, w_b} + {{DW{1'b0}}, w_cin};
            w_nib  = {1'b0, w_a[3:0]} + {1'b0, w_b[3:0]} + {4'b0000, w_cin};
            w_res  = w_wide[DW-1:0];
            w_cy   = w_wide[DW];
            w_ac   = w_nib[4];
         end
         3'b001: begin
            w_wide = {1'b0, w_a} - {1'b0, w_b} - {{DW{1'b0}}, w_cin};
            w_nib  = {1'b0, w_a[3:0]} - {1'b0, w_b[3:0]} - {4'b0000, w_cin};
            w_res  = w_wide[DW-1:0];
            w_cy   = w_wide[DW];
            w_ac   = w_nib[4];
         end
         3'b010: begin
            w_res = w_a & w_b;
            w_ac  = 1'b1;
         end
         3'b011: w_res = w_a | w_b;
         3'b100: w_res = w_a ^ w_b;
         default: w_op_ok = 1'b0;
      endcase
   end

   assign w_new_flags = {w_res[DW-1], (w_res == '0), w_ac, ~^w_res, w_cy};

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_valid  <= 1'b0;
         r_result <= '0;
         r_rd     <= '0;
         r_wr_en  <= 1'b0;
         r_flags  <= '0;
         r_err    <= 1'b0;
      end else if (flush) begin
         r_valid <= 1'b0;
         r_wr_en <= 1'b0;
         r_err   <= 1'b0;
      end else if (stall) begin
         r_err <= 1'b0;
      end else if (valid_in) begin
         r_valid <= 1'b1;
         r_rd    <= rd_in;
         if (w_op_ok) begin
            r_result <= w_res;
            r_wr_en  <= wr_en_in;
            r_err    <= 1'b0;
            if (flag_we_in)
               r_flags <= w_new_flags;
         end else begin
            r_result <= '0;
            r_wr_en  <= 1'b0;
            r_err    <= 1'b1;
         end
      end else begin
         r_valid <= 1'b0;
         r_wr_en <= 1'b0;
         r_err   <= 1'b0;
      end
   end

   assign valid_out  = r_valid;
   assign result_out = r_result;
   assign rd_out     = r_rd;
   assign wr_en_out  = r_wr_en;
   assign flags_out  = r_flags;
   assign err_out    = r_err;

endmodule

// File: tb/tb_ex_stage_8085_pipeline.sv
// tb/tb_ex_stage_8085_pipeline.sv - scoreboard bench for ex_stage_8085_pipeline with an arithmetic reference model
module tb_ex_stage_8085_pipeline;

   logic       clk = 1'b0;
   logic       rst_n, valid_in, use_cy_in, wr_en_in, flag_we_in, stall, flush;
   logic [2:0] op, src_a_in, src_b_in, rd_in;
   logic [7:0] a_in, b_in;
   logic       valid_out, wr_en_out, err_out;
   logic [7:0] result_out;
   logic [2:0] rd_out;
   logic [4:0] flags_out;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic       v;
      logic [7:0] res;
      logic [2:0] rd;
      logic       wr;
      logic [4:0] fl;
      logic       err;
      logic       chk_res;
   } exp_t;

   exp_t q[$];

   // reference model state
   logic       m_v = 0, m_wr = 0, m_err = 0;
   logic [7:0] m_res = 0;
   logic [2:0] m_rd = 0;
   logic [4:0] m_fl = 0;

   ex_stage_8085_pipeline dut (
      .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .op(op), .a_in(a_in), .b_in(b_in),
      .src_a_in(src_a_in), .src_b_in(src_b_in), .use_cy_in(use_cy_in), .rd_in(rd_in),
      .wr_en_in(wr_en_in), .flag_we_in(flag_we_in), .stall(stall), .flush(flush),
      .valid_out(valid_out), .result_out(result_out), .rd_out(rd_out), .wr_en_out(wr_en_out),
      .flags_out(flags_out), .err_out(err_out)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   initial begin : monitor
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (q.size() > 0) begin
            e = q.pop_front();
            check("valid_out", valid_out, e.v);
            check("wr_en_out", wr_en_out, e.wr);
            check("flags_out", flags_out, e.fl);
            check("err_out", err_out, e.err);
            if (e.chk_res) begin
               check("result_out", result_out, e.res);
               check("rd_out", rd_out, e.rd);
            end
         end
      end
   end

   function automatic logic even_parity(input int r);
      int ones = 0;
      for (int i = 0; i < 8; i++) ones += (r >> i) & 1;
      return (ones % 2) == 0;
   endfunction

   task automatic step(input logic rn, input logic v, input logic st, input logic fl,
                       input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                       input logic [2:0] sa, input logic [2:0] sb, input logic [2:0] rd,
                       input logic uc, input logic wr, input logic fwe);
      int ai, bi, ci, r, cy, ac;
      exp_t e;
      @(negedge clk);
      rst_n = rn; valid_in = v; stall = st; flush = fl; op = o; a_in = a; b_in = b;
      src_a_in = sa; src_b_in = sb; rd_in = rd; use_cy_in = uc; wr_en_in = wr; flag_we_in = fwe;

      ai = a; bi = b;
`ifdef EX_FWD_EN
      if (m_v && m_wr && m_rd == sa) ai = m_res;
      if (m_v && m_wr && m_rd == sb) bi = m_res;
`endif
      ci = (uc && m_fl[0]) ? 1 : 0;
      e.chk_res = 0;
      if (!rn) begin
         m_v = 0; m_res = 0; m_rd = 0; m_wr = 0; m_fl = 0; m_err = 0;
         e.chk_res = 1;
      end else if (fl) begin
         m_v = 0; m_wr = 0; m_err = 0;
      end else if (st) begin
         m_err = 0;
      end else if (!v) begin
         m_v = 0; m_wr = 0; m_err = 0;
      end else begin
         m_v = 1; m_rd = rd;
         if (o > 3'd4) begin
            m_res = 0; m_wr = 0; m_err = 1;
         end else begin
            cy = 0; ac = 0;
            case (o)
               3'd0: begin r = ai + bi + ci; cy = r > 255; ac = (ai % 16 + bi % 16 + ci) > 15; end
               3'd1: begin r = ai - bi - ci; cy = r < 0; ac = (ai % 16 - bi % 16 - ci) < 0; end
               3'd2: begin r = ai & bi; ac = 1; end
               3'd3: r = ai | bi;
               default: r = ai ^ bi;
            endcase
            r = r & 8'hFF;
            m_res = r[7:0]; m_wr = wr; m_err = 0;
            if (fwe) m_fl = {r[7], r == 0, ac[0], even_parity(r), cy[0]};
         end
      end
      e.v = m_v; e.res = m_res; e.rd = m_rd; e.wr = m_wr; e.fl = m_fl; e.err = m_err;
      e.chk_res = e.chk_res | m_v;
      q.push_back(e);
   endtask

   task automatic alu(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                      input logic uc, input logic wr, input logic fwe);
      step(1, 1, 0, 0, o, a, b, 3'd0, 3'd1, 3'd2, uc, wr, fwe);
   endtask

   initial begin : stim
      int waited;
      rst_n = 0; valid_in = 0; stall = 0; flush = 0; op = 0; a_in = 0; b_in = 0;
      src_a_in = 0; src_b_in = 0; rd_in = 0; use_cy_in = 0; wr_en_in = 0; flag_we_in = 0;

      repeat (2) step(0, 1, $urandom_range(0, 1), $urandom_range(0, 1), 3'($urandom_range(0, 7)),
                      8'($urandom), 8'($urandom), 3'($urandom), 3'($urandom), 3'($urandom), 1, 1, 1);

      alu(3'd0, 8'h3A, 8'hC6, 0, 1, 1);
      alu(3'd0, 8'hFF, 8'h00, 1, 1, 1);
      alu(3'd1, 8'h10, 8'h20, 0, 1, 1);
      alu(3'd1, 8'h10, 8'h20, 0, 0, 1);
      alu(3'd2, 8'hF0, 8'h0F, 0, 1, 1);
      alu(3'd7, 8'h12, 8'h34, 0, 1, 1);
      alu(3'd5, 8'h00, 8'h00, 0, 1, 1);
      alu(3'd4, 8'hA5, 8'h5A, 0, 1, 1);
      alu(3'd1, 8'h00, 8'h01, 1, 1, 1);
      alu(3'd3, 8'h00, 8'h00, 0, 1, 0);

      for (int i = 0; i < 3; i++)
         step(1, 1, 1, 0, 3'($urandom_range(0, 4)), 8'($urandom), 8'($urandom),
              3'd0, 3'd1, 3'($urandom), 1, 1, 1);
      step(1, 1, 1, 1, 3'd0, 8'h01, 8'h01, 3'd0, 3'd1, 3'd2, 0, 1, 1);
      step(0, 1, 1, 0, 3'd0, 8'h01, 8'h01, 3'd0, 3'd1, 3'd2, 0, 1, 1);
      step(0, 1, 0, 1, 3'd0, 8'h01, 8'h01, 3'd0, 3'd1, 3'd2, 0, 1, 1);

      step(1, 1, 0, 0, 3'd0, 8'h02, 8'h03, 3'd0, 3'd1, 3'd7, 0, 1, 1);
      step(1, 1, 0, 0, 3'd0, 8'h00, 8'h01, 3'd7, 3'd0, 3'd3, 0, 1, 1);

      for (int i = 0; i < 400; i++)
         step($urandom_range(0, 49) != 0, $urandom_range(0, 4) != 0,
              $urandom_range(0, 6) == 0, $urandom_range(0, 9) == 0,
              3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
              3'($urandom), 3'($urandom), 3'($urandom),
              1'($urandom), 1'($urandom), $urandom_range(0, 3) != 0);

      @(negedge clk);
      valid_in = 0;
      waited = 0;
      while (q.size() > 0 && waited < 10) begin
         @(negedge clk);
         waited++;
      end
      checks++;
      if (q.size() != 0) begin
         failures++;
         $display("FAIL drain: %0d expected entries left, expected 0", q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ex_stage_8085_pipeline.md
Name: ex_stage_8085_pipeline

Overview:
Execute stage of the pipelined 8085 processor, directly downstream of the ALU control decoder. Takes the decoder's 3-bit op, operands and writeback controls from ID. Computes the 8-bit ALU result and updates the architectural flag register (S,Z,AC,P,CY). Registers everything into the EX/MEM pipeline register, with stall and flush handshakes.

Parameters:
DW, 8, datapath width (only 8 is supported; flag rules assume 8)
RW, 3, register-index width (B,C,D,E,H,L,M,A encoding)

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
valid_in  in  1  ID/EX holds a valid instruction
op  in  3  ALU op: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR; others invalid
a_in  in  DW  operand A (accumulator side)
b_in  in  DW  operand B (register/immediate)
src_a_in  in  RW  register index of operand A (used by the forwarding option)
src_b_in  in  RW  register index of operand B (used by the forwarding option)
use_cy_in  in  1  add current CY (ADC) or subtract CY (SBB)
rd_in  in  RW  destination register index
wr_en_in  in  1  result to be written back (0 for CMP)
flag_we_in  in  1  instruction updates flags
stall  in  1  hold EX/MEM and flags this cycle
flush  in  1  kill the instruction entering EX this cycle
valid_out  out  1  EX/MEM holds a valid instruction
result_out  out  DW  registered ALU result
rd_out  out  RW  registered destination index
wr_en_out  out  1  registered write enable, gated by valid
flags_out  out  5  {S,Z,AC,P,CY} architectural flag register
err_out  out  1  one-cycle pulse: valid instruction carried an invalid op

Behaviour:
- Clock and reset: single clock clk. Reset is synchronous, active-low, on rst_n. rst_n=0 at a rising edge clears all outputs to 0, including flags_out=5'b00000 and err_out=0.
- Priority per edge: reset > flush > stall > normal capture.
- Latency: 1 cycle. Inputs sampled at edge N appear on the outputs after edge N.
- Normal capture (valid_in=1, no stall/flush): result_out, rd_out and wr_en_out load; valid_out=1.
- Flags: if flag_we_in=1, flags_out loads the new flags at the same edge. The next instruction therefore sees updated CY; no flag hazard exists.
- valid_in=0: valid_out=0, wr_en_out=0, flags hold, result_out don't-care (implement as hold).
- stall=1: all EX/MEM outputs and flags hold; err_out=0.
- flush=1: valid_out=0, wr_en_out=0, flags hold, err_out=0. Flush overrides a simultaneous stall.
- Arithmetic:
  - ADD: 9-bit sum a+b+(use_cy_in&CY). CY=bit8. AC=carry out of bit 3.
  - SUB: a-b-(use_cy_in&CY). CY=1 on borrow. AC=1 on borrow out of bit 3.
  - AND: CY=0, AC=1.
  - OR and XOR: CY=0, AC=0.
  - Z=(result==0). S=result[7]. P=1 when result has even parity.
- Invalid op (101,110,111 or any x/z) with valid_in=1 and no stall/flush:
  - result_out=0, wr_en_out=0, flags hold, valid_out=1.
  - err_out=1 for exactly one cycle.
- Reset mid-stall or mid-flush: reset wins; the outputs come up cleared on the next edge.

Optional Feature:
Macro EX_FWD_EN enables EX-to-EX forwarding.
- Defined: when valid_out=1 and wr_en_out=1:
  - if rd_out==src_a_in, operand A is replaced by result_out;
  - if rd_out==src_b_in, operand B is replaced by result_out;
  - the two substitutions are independent.
- Not defined: a_in and b_in are used as given, and src_a_in/src_b_in are ignored (left unconnected internally).

Test Plan:
- Reset: hold rst_n=0 for 2 edges with random inputs -> all outputs 0, flags_out=00000; release -> first valid ADD appears one edge later.
- ADD a=0x3A, b=0xC6, flag_we=1 -> result 0x00, flags {S,Z,AC,P,CY}={0,1,1,1,1}, wr_en_out=1. Follow with ADC a=0xFF, b=0x00 -> result 0x00, CY=1.
- SUB a=0x10, b=0x20 -> result 0xF0, S=1, Z=0, AC=0, P=1, CY=1. CMP (same with wr_en_in=0) -> identical flags, wr_en_out=0.
- AND 0xF0&0x0F -> 0x00, Z=1, AC=1, CY=0. Then op=3'b111 -> err_out pulses 1 cycle, result 0, flags unchanged.
- Stall 3 cycles with changing inputs -> outputs and flags frozen. stall=1 with flush=1 -> valid_out=0, flags unchanged.
- With EX_FWD_EN: ADD writes rd=7 result 0x05; next instruction src_a=7, a_in=0x00, b_in=0x01 -> result 0x06. Without the macro -> 0x01.
